// File: rtl/regfile_dumper.sv
// Walks the register-file read port and streams every word out as UART 8N1 bytes, MSB byte first.
// Define REGFILE_DUMP_HEADER_EN to prefix each register with a header byte holding its index.
module regfile_dumper #(
    parameter int BUS_WIDTH     = 32,
    parameter int NUM_REGS      = 32,
    parameter int CLK_FREQUENCY = 100_000_000,
    parameter int BAUD_RATE     = 19_200
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic [4:0]           readReg,
    input  logic [BUS_WIDTH-1:0] readData,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    // state | meaning
    // IDLE  | line idle, waiting for start
    // LOAD  | capture readData for the current index
    // SEND  | shift bytes of the current register out on tx
    // NEXT  | advance index or finish
    // DONE  | one-cycle done pulse
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_SEND = 3'd2;
    localparam logic [2:0] S_NEXT = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam int BAUD_DIV = CLK_FREQUENCY / BAUD_RATE;
    localparam int BYTES    = BUS_WIDTH / 8;
`ifdef REGFILE_DUMP_HEADER_EN
    localparam int BPR = BYTES + 1;
`else
    localparam int BPR = BYTES;
`endif
    localparam int BCW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int BIW = (BPR > 1) ? $clog2(BPR) : 1;

    localparam logic [BCW-1:0] BAUD_LAST = BCW'(BAUD_DIV - 1);
    localparam logic [BIW-1:0] BYTE_LAST = BIW'(BPR - 1);
    localparam logic [4:0]     REG_LAST  = 5'(NUM_REGS - 1);
    localparam logic [3:0]     BIT_STOP  = 4'd9;

    logic [2:0]           state_q, state_d;
    logic [4:0]           reg_idx_q, reg_idx_d;
    logic [BUS_WIDTH-1:0] cap_q, cap_d;
    logic [BIW-1:0]       byte_idx_q, byte_idx_d;
    logic [BCW-1:0]       baud_q, baud_d;
    logic [3:0]           bit_q, bit_d;
    logic                 tx_q, tx_d;
    logic                 shift_en;
    logic [7:0]           byte_d;

    // The capture register shifts left one byte after each data byte, so the
    // outgoing data byte always sits in its top 8 bits.
`ifdef REGFILE_DUMP_HEADER_EN
    assign shift_en = (byte_idx_q != '0);
    assign byte_d   = (byte_idx_d == '0) ? {3'b000, reg_idx_d} : cap_d[BUS_WIDTH-1 -: 8];
`else
    assign shift_en = 1'b1;
    assign byte_d   = cap_d[BUS_WIDTH-1 -: 8];
`endif

    always_comb begin
        state_d    = state_q;
        reg_idx_d  = reg_idx_q;
        cap_d      = cap_q;
        byte_idx_d = byte_idx_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        case (state_q)
            S_IDLE: begin
                reg_idx_d = '0;
                if (start) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                cap_d      = readData;
                byte_idx_d = '0;
                baud_d     = '0;
                bit_d      = '0;
                state_d    = S_SEND;
            end
            S_SEND: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (bit_q == BIT_STOP) begin
                        bit_d = '0;
                        if (shift_en) begin
                            cap_d = cap_q << 8;
                        end
                        if (byte_idx_q == BYTE_LAST) begin
                            state_d = S_NEXT;
                        end else begin
                            byte_idx_d = byte_idx_q + 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_NEXT: begin
                if (reg_idx_q == REG_LAST) begin
                    state_d = S_DONE;
                end else begin
                    reg_idx_d = reg_idx_q + 1'b1;
                    state_d   = S_LOAD;
                end
            end
            S_DONE: begin
                reg_idx_d = '0;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // tx is registered from the next-state view so the line never glitches.
    always_comb begin
        tx_d = 1'b1;
        if (state_d == S_SEND) begin
            if (bit_d == 4'd0) begin
                tx_d = 1'b0;
            end else if (bit_d <= 4'd8) begin
                tx_d = byte_d[3'(bit_d - 4'd1)];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            reg_idx_q  <= '0;
            cap_q      <= '0;
            byte_idx_q <= '0;
            baud_q     <= '0;
            bit_q      <= '0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            reg_idx_q  <= reg_idx_d;
            cap_q      <= cap_d;
            byte_idx_q <= byte_idx_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            tx_q       <= tx_d;
        end
    end

    assign readReg = reg_idx_q;
    assign tx      = tx_q;
    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);

endmodule

// File: tb/tb_regfile_dumper.sv
// Self-checking bench for regfile_dumper: randomized register contents, UART line
// decoded from a per-cycle trace and compared with a word-level byte-stream model.
module tb_regfile_dumper;

    localparam int BW   = 32;
    localparam int NR   = 2;
    localparam int CLKF = 76_800;
    localparam int BAUD = 19_200;
    localparam int BD   = CLKF / BAUD;
`ifdef REGFILE_DUMP_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif
    localparam int BPR      = BW / 8 + HDR;
    localparam int DUMP_CYC = NR * (2 + BPR * 10 * BD);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [4:0]    readReg;
    logic [BW-1:0] readData;
    logic          tx;
    logic          busy;
    logic          done;

    logic [BW-1:0] rf   [0:31];
    logic [BW-1:0] snap [0:NR-1];
    logic          trace[$];
    logic [7:0]    exp_q[$];
    logic [7:0]    got_q[$];
    bit            rec_en = 1'b0;
    int            done_seen = 0;
    int            frame_err = 0;
    int            n_checks = 0;
    int            n_pass = 0;

    assign readData = rf[readReg];

    always #5 clk = ~clk;

    regfile_dumper #(
        .BUS_WIDTH(BW),
        .NUM_REGS(NR),
        .CLK_FREQUENCY(CLKF),
        .BAUD_RATE(BAUD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .readReg(readReg),
        .readData(readData),
        .tx(tx),
        .busy(busy),
        .done(done)
    );

    always @(negedge clk) begin
        if (rec_en) trace.push_back(tx);
        if (done === 1'b1) done_seen++;
    end

    function automatic void build_expected();
        exp_q.delete();
        for (int r = 0; r < NR; r++) begin
            if (HDR != 0) exp_q.push_back(8'(r));
            for (int k = BW / 8 - 1; k >= 0; k--) exp_q.push_back(8'(snap[r] >> (8 * k)));
        end
    endfunction

    function automatic void decode_trace();
        int i;
        i = 0;
        got_q.delete();
        frame_err = 0;
        while (i < trace.size()) begin
            if (trace[i] === 1'b0) begin
                logic [7:0] b;
                int         sp;
                b = '0;
                for (int k = 0; k < 8; k++) begin
                    int s;
                    s = i + (k + 1) * BD + BD / 2;
                    b[k] = (s < trace.size()) ? trace[s] : 1'bx;
                end
                sp = i + 9 * BD + BD / 2;
                if (sp >= trace.size() || trace[sp] !== 1'b1) frame_err++;
                got_q.push_back(b);
                i += 10 * BD;
            end else begin
                i++;
            end
        end
    endfunction

    function automatic int stream_errors();
        int e;
        build_expected();
        decode_trace();
        e = frame_err;
        if (got_q.size() != exp_q.size()) e++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            if (got_q[i] !== exp_q[i]) e++;
        return e;
    endfunction

    // Starts a dump from an idle cycle and returns edges from the start-sampling edge to done.
    // At poke_at edges it pulses start again and overwrites reg0 with its complement.
    task automatic run_dump(input int poke_at, output int lat, output logic busy_load);
        int cnt;
        cnt = 0;
        for (int r = 0; r < NR; r++) snap[r] = rf[r];
        trace.delete();
        done_seen = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        busy_load = busy;
        rec_en    = 1'b1;
        while (done !== 1'b1 && cnt < DUMP_CYC + 20) begin
            @(posedge clk); #1;
            cnt++;
            if (cnt == poke_at) begin
                start = 1'b1;
                rf[0] = ~rf[0];
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        lat = cnt;
        @(posedge clk); #1;
        rec_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        #12;
        n_checks++; if (tx !== 1'b1) $display("FAIL reset_tx: got %b expected 1", tx); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else n_pass++;
        n_checks++; if (readReg !== 5'd0) $display("FAIL reset_readReg: got %0d expected 0", readReg); else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_release_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (tx !== 1'b1) $display("FAIL reset_release_tx: got %b expected 1", tx); else n_pass++;
    endtask

    task automatic test_basic();
        int   lat;
        int   e;
        logic bl;
        rf[0] = 32'h1234_5678;
        rf[1] = 32'hDEAD_BEEF;
        run_dump(-1, lat, bl);
        n_checks++; if (bl !== 1'b1) $display("FAIL basic_busy_load: got %b expected 1", bl); else n_pass++;
        n_checks++; if (lat != DUMP_CYC) $display("FAIL basic_latency: got %0d expected %0d", lat, DUMP_CYC); else n_pass++;
        e = stream_errors();
        n_checks++; if (got_q.size() != exp_q.size()) $display("FAIL basic_count: got %0d bytes expected %0d", got_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) $display("FAIL basic_byte%0d: got %02h expected %02h", i, got_q[i], exp_q[i]);
            else n_pass++;
        end
        n_checks++; if (frame_err != 0) $display("FAIL basic_framing: got %0d bad stop bits expected 0", frame_err); else n_pass++;
        n_checks++; if (done_seen != 1) $display("FAIL basic_done_width: got %0d cycles expected 1", done_seen); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL basic_busy_fall: got %b expected 0", busy); else n_pass++;
        n_checks++; if (readReg !== 5'd0) $display("FAIL basic_idle_readReg: got %0d expected 0", readReg); else n_pass++;
    endtask

    task automatic test_bit_timing();
        int   lat;
        int   f0;
        logic bl;
        logic ok;
        logic lvl;
        logic exp_bits [0:9];
        exp_bits = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        rf[0] = {8'hA5, 24'($urandom())};
        rf[1] = $urandom();
        run_dump(-1, lat, bl);
        f0 = 1 + HDR * 10 * BD;
        n_checks++; if (trace.size() < f0 + 10 * BD) $display("FAIL bit_trace_len: got %0d expected >= %0d", trace.size(), f0 + 10 * BD); else n_pass++;
        if (trace.size() >= f0 + 10 * BD) begin
            n_checks++; if (trace[f0 - 1] !== 1'b1) $display("FAIL bit_pre_start: got %b expected 1", trace[f0 - 1]); else n_pass++;
            for (int k = 0; k < 10; k++) begin
                ok  = 1'b1;
                lvl = 1'b1;
                for (int c = 0; c < BD; c++) begin
                    if (trace[f0 + k * BD + c] !== exp_bits[k]) begin
                        ok  = 1'b0;
                        lvl = trace[f0 + k * BD + c];
                    end
                end
                n_checks++;
                if (!ok) $display("FAIL bit_level%0d: got %b within %0d-cycle hold expected %b", k, lvl, BD, exp_bits[k]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_random();
        int   lat;
        int   e;
        logic bl;
        for (int it = 0; it < 4; it++) begin
            for (int r = 0; r < NR; r++) rf[r] = $urandom();
            run_dump(-1, lat, bl);
            e = stream_errors();
            n_checks++; if (lat != DUMP_CYC) $display("FAIL rand%0d_latency: got %0d expected %0d", it, lat, DUMP_CYC); else n_pass++;
            n_checks++; if (e != 0) $display("FAIL rand%0d_stream: got %0d byte/frame errors expected 0", it, e); else n_pass++;
        end
    endtask

    task automatic test_start_while_busy();
        int   lat;
        int   e;
        logic bl;
        for (int r = 0; r < NR; r++) rf[r] = $urandom();
        run_dump(60, lat, bl);
        e = stream_errors();
        n_checks++; if (lat != DUMP_CYC) $display("FAIL busy_start_latency: got %0d expected %0d", lat, DUMP_CYC); else n_pass++;
        n_checks++; if (e != 0) $display("FAIL busy_write_stream: got %0d byte/frame errors expected 0", e); else n_pass++;
        n_checks++; if (done_seen != 1) $display("FAIL busy_start_done: got %0d pulses expected 1", done_seen); else n_pass++;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL busy_start_no_restart: got busy %b expected 0", busy); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int         lat;
        int         e;
        int         diff;
        logic       bl;
        logic [7:0] q1[$];
        for (int r = 0; r < NR; r++) rf[r] = $urandom();
        run_dump(-1, lat, bl);
        e  = stream_errors();
        q1 = got_q;
        n_checks++; if (e != 0) $display("FAIL b2b_first_stream: got %0d errors expected 0", e); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL b2b_busy_low: got %b expected 0", busy); else n_pass++;
        run_dump(-1, lat, bl);
        e = stream_errors();
        n_checks++; if (bl !== 1'b1) $display("FAIL b2b_accept: got busy %b expected 1", bl); else n_pass++;
        n_checks++; if (lat != DUMP_CYC) $display("FAIL b2b_latency: got %0d expected %0d", lat, DUMP_CYC); else n_pass++;
        n_checks++; if (e != 0) $display("FAIL b2b_second_stream: got %0d errors expected 0", e); else n_pass++;
        diff = (got_q.size() == q1.size()) ? 0 : 1;
        for (int i = 0; i < q1.size() && i < got_q.size(); i++) if (got_q[i] !== q1[i]) diff++;
        n_checks++; if (diff != 0) $display("FAIL b2b_identical: got %0d differences expected 0", diff); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int   lat;
        int   e;
        int   hit;
        logic bl;
        for (int r = 0; r < NR; r++) rf[r] = $urandom();
        done_seen = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // reg1 LOAD is cycle 2+B*10*BD; land a few bit times into its first data bits
        repeat (2 + BPR * 10 * BD + 1 + 2 * BD + 1) @(posedge clk);
        #3;
        n_checks++; if (readReg !== 5'd1) $display("FAIL rstmid_pre_readReg: got %0d expected 1", readReg); else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++; if (tx !== 1'b1) $display("FAIL rstmid_tx: got %b expected 1", tx); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (readReg !== 5'd0) $display("FAIL rstmid_readReg: got %0d expected 0", readReg); else n_pass++;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        hit = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (busy !== 1'b0 || tx !== 1'b1) hit++;
        end
        n_checks++; if (done_seen != 0) $display("FAIL rstmid_no_done: got %0d pulses expected 0", done_seen); else n_pass++;
        n_checks++; if (hit != 0) $display("FAIL rstmid_idle_after: got %0d active cycles expected 0", hit); else n_pass++;
        run_dump(-1, lat, bl);
        e = stream_errors();
        n_checks++; if (lat != DUMP_CYC) $display("FAIL rstmid_restart_latency: got %0d expected %0d", lat, DUMP_CYC); else n_pass++;
        n_checks++; if (e != 0) $display("FAIL rstmid_restart_stream: got %0d errors expected 0", e); else n_pass++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int r = 0; r < 32; r++) rf[r] = '0;
        test_reset();
        test_basic();
        test_bit_timing();
        test_random();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
